// File: rtl/cc_miss_request_scheduler.sv
// cc_miss_request_scheduler: issues one 8-beat AXI refill read per miss, pushes the miss address
// to the fill FIFO and throttles new misses at MAX_OUTSTANDING refills in flight.
// Optional feature macro: CC_CRITICAL_WORD_FIRST_EN (word-aligned WRAP bursts, critical word first).
module cc_miss_request_scheduler #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_req_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_ready_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arid_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic [3:0]  outstanding_o,
    output logic        err_o
);
    typedef enum logic {IDLE, AR_WAIT} state_t;
`ifdef CC_CRITICAL_WORD_FIRST_EN
    localparam logic [31:0] ADDR_MASK = 32'hffff_fff8;
    localparam logic [1:0]  BURST     = 2'b10;
`else
    localparam logic [31:0] ADDR_MASK = 32'hffff_ffc0;
    localparam logic [1:0]  BURST     = 2'b01;
`endif
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);
    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [3:0]  cnt_q;
    logic        err_q, push_q, accept, rlast_hs;
    assign miss_ready_o           = (state_q == IDLE) & (cnt_q < MAX_CNT) & ~miss_addr_fifo_full_i;
    assign mem_arvalid_o          = state_q == AR_WAIT;
    assign accept                 = miss_req_i & miss_ready_o;
    assign rlast_hs               = mem_rvalid_i & mem_rready_i & mem_rlast_i;
    assign mem_araddr_o           = addr_q & ADDR_MASK;
    assign miss_addr_fifo_wdata_o = addr_q & ADDR_MASK;
    assign miss_addr_fifo_wren_o  = push_q;
    assign mem_arid_o             = 4'd0;
    assign mem_arlen_o            = 4'd7;
    assign mem_arsize_o           = 3'd3;
    assign mem_arburst_o          = BURST;
    assign outstanding_o          = cnt_q;
    assign err_o                  = err_q;
    // Next state: accept a miss from IDLE, return to IDLE on the AR handshake
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (accept ? AR_WAIT : IDLE) : (mem_arready_i ? IDLE : AR_WAIT);
    end
    // State register, captured miss address and one-cycle FIFO push on entering AR_WAIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            push_q  <= accept;
            if (accept) addr_q <= miss_addr_i;
        end
    end
    // In-flight refill count; an RLAST with nothing in flight is flagged and never underflows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + {3'b0, accept} - {3'b0, rlast_hs & (cnt_q != 4'd0)};
            err_q <= err_q | (rlast_hs & (cnt_q == 4'd0));
        end
    end
endmodule

// File: tb/tb_cc_miss_request_scheduler.sv
// tb_cc_miss_request_scheduler: directed and random stimulus scored against a transaction-level model.
module tb_cc_miss_request_scheduler;
    localparam int MAX = 4;
`ifdef CC_CRITICAL_WORD_FIRST_EN
    localparam logic [31:0] MASK = 32'hffff_fff8;
    localparam logic [1:0]  BURST = 2'b10;
`else
    localparam logic [31:0] MASK = 32'hffff_ffc0;
    localparam logic [1:0]  BURST = 2'b01;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic miss_req = 1'b0, arready = 1'b0, rvalid = 1'b0, rready = 1'b0, rlast = 1'b0, full = 1'b0;
    logic [31:0] miss_addr = '0;
    logic miss_ready, arvalid, wren, err;
    logic [31:0] araddr, wdata;
    logic [3:0] arid, arlen, outstanding;
    logic [2:0] arsize;
    logic [1:0] arburst;
    int total_cnt = 0, pass_cnt = 0;
    // reference model: one AR in flight at most, a count of refills awaiting RLAST, sticky error
    int m_cnt = 0;
    bit m_busy = 0, m_err = 0, m_push_due = 0, m_fresh = 1;
    logic [31:0] exp_ar[$];
    logic [31:0] exp_push[$];

    cc_miss_request_scheduler #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req_i(miss_req), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready),
        .mem_arvalid_o(arvalid), .mem_arready_i(arready), .mem_araddr_o(araddr),
        .mem_arid_o(arid), .mem_arlen_o(arlen), .mem_arsize_o(arsize), .mem_arburst_o(arburst),
        .mem_rvalid_i(rvalid), .mem_rready_i(rready), .mem_rlast_i(rlast),
        .miss_addr_fifo_full_i(full), .miss_addr_fifo_wren_o(wren),
        .miss_addr_fifo_wdata_o(wdata), .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // monitor/scoreboard: compare on the falling edge, then advance the model across the next rising edge
    always @(negedge clk) begin
        bit exp_rdy, acc, hs, rl;
        exp_rdy = !m_busy && (m_cnt < MAX) && !full;
        chk("miss_ready", 32'(miss_ready), 32'(exp_rdy));
        chk("arvalid", 32'(arvalid), 32'(m_busy));
        chk("outstanding", 32'(outstanding), 32'(m_cnt));
        chk("err", 32'(err), 32'(m_err));
        chk("fifo_wren", 32'(wren), 32'(m_push_due));
        chk("ar_consts", {21'd0, arid, arlen, arsize}, {21'd0, 4'd0, 4'd7, 3'd3});
        chk("arburst", 32'(arburst), 32'(BURST));
        if (m_fresh) begin
            chk("araddr_rst", araddr, 32'd0);
            chk("wdata_rst", wdata, 32'd0);
        end
        if (m_push_due && wren && exp_push.size() > 0) chk("fifo_wdata", wdata, exp_push.pop_front());
        if (m_busy && exp_ar.size() > 0) chk("araddr", araddr, exp_ar[0]);
        if (!rst_n) begin
            m_cnt = 0; m_busy = 0; m_err = 0; m_push_due = 0; m_fresh = 1;
            exp_ar.delete();
            exp_push.delete();
        end else begin
            acc = miss_req && exp_rdy;
            hs = m_busy && arready;
            rl = rvalid && rready && rlast;
            if (hs && exp_ar.size() > 0) void'(exp_ar.pop_front());
            if (rl && m_cnt == 0) m_err = 1;
            m_cnt = m_cnt + int'(acc) - int'(rl && m_cnt > 0);
            m_busy = acc ? 1'b1 : (hs ? 1'b0 : m_busy);
            m_push_due = acc;
            if (acc) begin
                m_fresh = 0;
                exp_ar.push_back(miss_addr & MASK);
                exp_push.push_back(miss_addr & MASK);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rlast_beats(input int n);
        rvalid = 1; rready = 1; rlast = 1;
        tick(n);
        rvalid = 0; rready = 0; rlast = 0;
    endtask

    initial begin
        tick(3);
        rst_n = 1;
        tick(1);
        // single miss with AR ready, then 7 data beats and RLAST
        miss_req = 1; miss_addr = 32'h1234_5678; arready = 1;
        tick(1);
        miss_req = 0;
        tick(3);
        rvalid = 1; rready = 1;
        tick(7);
        rlast_beats(1);
        tick(2);
        // AR backpressure for 10 cycles with the request held
        arready = 0; miss_req = 1; miss_addr = $urandom;
        tick(1);
        miss_addr = $urandom;
        tick(10);
        miss_req = 0; arready = 1;
        tick(2);
        rlast_beats(1);
        tick(1);
        // outstanding limit with back-to-back misses, then one RLAST frees a slot
        miss_req = 1;
        for (int i = 0; i < 12; i++) begin
            miss_addr = $urandom;
            tick(1);
        end
        rlast_beats(1);
        tick(2);
        miss_req = 0;
        tick(2);
        rlast_beats(5);
        tick(1);
        // accept and RLAST in the same cycle at outstanding 2
        miss_req = 1; miss_addr = $urandom;
        tick(4);
        miss_req = 0;
        tick(1);
        miss_req = 1; miss_addr = $urandom; rvalid = 1; rready = 1; rlast = 1;
        tick(1);
        miss_req = 0; rvalid = 0; rready = 0; rlast = 0;
        tick(2);
        rlast_beats(2);
        tick(1);
        // FIFO full blocks acceptance until released
        full = 1; miss_req = 1; miss_addr = $urandom;
        tick(5);
        full = 0;
        tick(1);
        miss_req = 0;
        tick(2);
        rlast_beats(1);
        tick(1);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            miss_req = 1'($urandom_range(0, 1));
            miss_addr = $urandom;
            arready = ($urandom % 4) != 0;
            full = ($urandom % 8) == 0;
            rvalid = 1'($urandom_range(0, 1));
            rready = ($urandom % 4) != 0;
            rlast = (m_cnt > 0) && (($urandom % 3) == 0);
            tick(1);
        end
        miss_req = 0; full = 0; arready = 1; rvalid = 0; rready = 0; rlast = 0;
        tick(3);
        // spurious RLAST after a fresh reset sets the sticky error
        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick(1);
        rlast_beats(1);
        tick(3);
        // reset while an AR is stalled
        arready = 0; miss_req = 1; miss_addr = $urandom;
        tick(1);
        miss_req = 0;
        tick(3);
        rst_n = 0;
        tick(1);
        rst_n = 1;
        tick(3);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/cc_miss_request_scheduler.md
# cc_miss_request_scheduler

Issues cache-line refill requests for the cache controller. Accepts one miss at a time from the hit/miss logic, drives the AXI AR channel with an 8-beat, 64-bit burst, and pushes the miss address into the miss-address FIFO that the data fill unit pops when R data returns. Tracks in-flight refills and throttles new misses at a configurable outstanding limit.

## Interface
- MAX_OUTSTANDING, default 4: maximum refills in flight (AR issued, RLAST not yet seen); legal range 1..15.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- miss_req_i  input  1  miss request valid.
- miss_addr_i  input  32  miss byte address; [31:15] tag, [14:6] index, [5:3] word offset.
- miss_ready_o  output  1  miss accepted when miss_req_i & miss_ready_o.
- mem_arvalid_o  output  1  AR valid.
- mem_arready_i  input  1  AR ready.
- mem_araddr_o  output  32  AR address.
- mem_arid_o  output  4  constant 0.
- mem_arlen_o  output  4  constant 7 (8 beats).
- mem_arsize_o  output  3  constant 3 (8 bytes).
- mem_arburst_o  output  2  burst type (see Configuration).
- mem_rvalid_i, mem_rready_i, mem_rlast_i  input  1 each  R-channel monitor.
- miss_addr_fifo_full_i  input  1  FIFO full.
- miss_addr_fifo_wren_o  output  1  FIFO push strobe.
- miss_addr_fifo_wdata_o  output  32  FIFO push data.
- outstanding_o  output  4  current in-flight refill count.
- err_o  output  1  sticky: RLAST seen with zero outstanding.

## Operation
- FSM: IDLE, AR_WAIT.
- miss_ready_o = (state==IDLE) & (outstanding_o < MAX_OUTSTANDING) & !miss_addr_fifo_full_i; combinational, no dependence on miss_req_i.
- Accept in IDLE: register request address into addr_q; next state AR_WAIT.
- AR_WAIT: mem_arvalid_o=1, mem_araddr_o from addr_q, held stable until mem_arready_i; on handshake -> IDLE.
- FIFO push: miss_addr_fifo_wren_o pulses exactly one cycle (first AR_WAIT cycle), wdata = addr_q. Push always precedes first R beat of that burst. Only this block writes the FIFO, so full sampled at accept remains valid at push.
- outstanding counter: +1 on accept; -1 on mem_rvalid_i & mem_rready_i & mem_rlast_i; both same cycle -> unchanged. Non-last beats ignored.
- RLAST with counter 0: counter stays 0, err_o set, cleared only by reset.
- mem_arid_o/arlen/arsize constant in all states including reset.

## Timing
- Reset values: state IDLE, mem_arvalid_o 0, mem_araddr_o 0, miss_addr_fifo_wren_o 0, miss_addr_fifo_wdata_o 0, outstanding_o 0, err_o 0; miss_ready_o 1 after reset if FIFO not full.
- Accept at cycle T -> mem_arvalid_o and FIFO push at T+1; earliest AR handshake T+1; next accept earliest T+2 (IDLE at T+2).
- outstanding_o increments visible T+1; decrement visible cycle after RLAST handshake.
- Counter at MAX: miss_ready_o low same cycle; RLAST at cycle R -> miss_ready_o high at R+1.
- mem_arready_i held low indefinitely: FSM stays AR_WAIT, arvalid/araddr stable, no further accepts.
- Reset asserted mid-AR_WAIT: arvalid drops next edge; in-flight count discarded (memory side also reset).

## Configuration
- CC_CRITICAL_WORD_FIRST_EN defined: mem_araddr_o = addr_q (word-aligned, [2:0] forced 0), mem_arburst_o = 2'b10 (WRAP); FIFO wdata = addr_q with [2:0]=0, so fill unit places beats from offset [5:3].
- Undefined: mem_araddr_o and FIFO wdata = addr_q with [5:0]=0 (line-aligned), mem_arburst_o = 2'b01 (INCR); fill unit sees offset 0.

## Test plan
- Single miss 0x1234_5678, arready=1: accept T, arvalid+FIFO push T+1, araddr 0x1234_5678&~7 (CWF) or 0x1234_5640 (no CWF), arburst 2/1, outstanding 1; RLAST returns -> 0.
- Backpressure: arready low 10 cycles after accept -> arvalid high 10 cycles with stable araddr, one FIFO push only, miss_ready_o low throughout.
- Limit: MAX_OUTSTANDING=4, 5 back-to-back misses, no R data -> 4 accepted, miss_ready_o low, outstanding 4; one RLAST -> 5th accepted next cycle.
- Simultaneous accept and RLAST at outstanding 2 -> stays 2.
- FIFO full asserted -> miss_ready_o 0, no AR; deassert -> accept next cycle.
- Spurious RLAST at outstanding 0 -> err_o 1, outstanding 0; mid-AR_WAIT reset -> all outputs to reset values next edge.
